tt_um_slarrk_core: RTL and testbench

//   Tiny Tapeout user block: 8-bit accumulator ALU with a 4-entry scratch register file.

---
 rtl/slarrk_pkg.sv | 33 +++
 rtl/slarrk_alu.sv | 91 +++++++++
 rtl/tt_um_slarrk_core.sv | 78 +++++++
 tb/tb_tt_um_slarrk_core.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/slarrk_pkg.sv
// Shared definitions for the slarrk accumulator ALU: opcode encoding and flag bit positions.
package slarrk_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LD  = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_SHL = 4'h7,
        OP_SHR = 4'h8,
        OP_ROL = 4'h9,
        OP_ROR = 4'hA,
        OP_ST  = 4'hB,
        OP_MOV = 4'hC,
        OP_ADR = 4'hD,
        OP_INC = 4'hE,
        OP_CLR = 4'hF
    } op_e;

    localparam int FZ = 0;
    localparam int FC = 1;
    localparam int FN = 2;
    localparam int FV = 3;

    // Z set, everything else clear: the flags of an all-zero accumulator
    localparam logic [3:0] FLAGS_RST = 4'b0001;

endpackage

// File: rtl/slarrk_alu.sv
// Combinational ALU: computes the next accumulator value and flag vector for one opcode.
module slarrk_alu (
    input  logic [3:0] op,
    input  logic [7:0] acc,
    input  logic [7:0] operand,
    input  logic       carry_in,
    output logic [7:0] result,
    output logic [3:0] flags,
    output logic       acc_we,
    output logic       flag_we
);
    import slarrk_pkg::*;

    op_e        op_dec;
    logic [8:0] add_sum;
    logic [8:0] sub_diff;
    logic [8:0] inc_sum;
    logic       c_new;
    logic       v_new;

    assign op_dec   = op_e'(op);
    assign add_sum  = {1'b0, acc} + {1'b0, operand};
    assign sub_diff = {1'b0, acc} - {1'b0, operand};
    assign inc_sum  = {1'b0, acc} + 9'd1;

    always_comb begin
        result  = acc;
        acc_we  = 1'b1;
        flag_we = 1'b1;
        c_new   = 1'b0;
        v_new   = 1'b0;
        case (op_dec)
            OP_NOP: begin
                acc_we  = 1'b0;
                flag_we = 1'b0;
            end
            OP_LD, OP_MOV: result = operand;
            OP_ADD, OP_ADR: begin
                result = add_sum[7:0];
                c_new  = add_sum[8];
                v_new  = (acc[7] == operand[7]) && (add_sum[7] != acc[7]);
            end
            // sub_diff[8] is the borrow, i.e. acc < operand unsigned
            OP_SUB: begin
                result = sub_diff[7:0];
                c_new  = sub_diff[8];
                v_new  = (acc[7] != operand[7]) && (sub_diff[7] != acc[7]);
            end
            OP_AND: result = acc & operand;
            OP_OR:  result = acc | operand;
            OP_XOR: result = acc ^ operand;
            OP_SHL: begin
                result = {acc[6:0], 1'b0};
                c_new  = acc[7];
            end
            OP_SHR: begin
                result = {1'b0, acc[7:1]};
                c_new  = acc[0];
            end
            OP_ROL: begin
                result = {acc[6:0], carry_in};
                c_new  = acc[7];
            end
            OP_ROR: begin
                result = {carry_in, acc[7:1]};
                c_new  = acc[0];
            end
            OP_ST: begin
                acc_we  = 1'b0;
                flag_we = 1'b0;
            end
            OP_INC: begin
                result = inc_sum[7:0];
                c_new  = inc_sum[8];
                v_new  = ~acc[7] & inc_sum[7];
            end
            OP_CLR: result = 8'h00;
            default: begin
                acc_we  = 1'b0;
                flag_we = 1'b0;
            end
        endcase

        flags     = 4'b0000;
        flags[FZ] = (result == 8'h00);
        flags[FC] = c_new;
        flags[FN] = result[7];
        flags[FV] = v_new;
    end

endmodule

// File: rtl/tt_um_slarrk_core.sv
// Tiny Tapeout user macro: 8-bit accumulator ALU with a 4-entry scratch register file,
// executed on the rising edge of a host strobe.
module tt_um_slarrk_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    import slarrk_pkg::*;

    logic [7:0] acc;
    logic [7:0] regs [0:3];
    logic [3:0] flags;
    logic [3:0] opcnt;
    logic       strobe_q;

    logic       fire;
    logic [3:0] op;
    logic [1:0] rsel;
    logic [7:0] operand;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic       acc_we;
    logic       flag_we;

    assign op   = ui_in[3:0];
    assign rsel = ui_in[5:4];
    assign fire = ena & ui_in[6] & ~strobe_q;

    // Register-sourced ops take their operand from the file instead of the bidir pins
    assign operand = (op == OP_MOV || op == OP_ADR) ? regs[rsel] : uio_in;

    slarrk_alu u_alu (
        .op       (op),
        .acc      (acc),
        .operand  (operand),
        .carry_in (flags[FC]),
        .result   (alu_result),
        .flags    (alu_flags),
        .acc_we   (acc_we),
        .flag_we  (flag_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= 8'h00;
            flags    <= FLAGS_RST;
            opcnt    <= 4'd0;
            strobe_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (ena) begin
            strobe_q <= ui_in[6];
            if (fire) begin
                opcnt <= opcnt + 4'd1;
                if (acc_we) begin
                    acc <= alu_result;
                end
                if (flag_we) begin
                    flags <= alu_flags;
                end
                if (op == OP_ST) begin
                    regs[rsel] <= acc;
                end
            end
        end
    end

    assign uo_out  = ui_in[7] ? {opcnt, flags} : acc;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_slarrk_core.sv
// Scoreboard bench for tt_um_slarrk_core: directed op sequences with hand-computed ACC/status values.
module tb_tt_um_slarrk_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q [$];
    string      name_q [$];
    logic       chk_req = 1'b0;
    logic [7:0] mon_exp;
    string      mon_name;

    tt_um_slarrk_core dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Monitor: one pop per check request, sampled just after the edge
    always @(posedge clk) begin
        if (chk_req) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got %h with no expected value", uo_out);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (uo_out !== mon_exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", mon_name, uo_out, mon_exp);
                end
            end
        end
    end

    task automatic exec(input logic [3:0] op, input logic [1:0] rs, input logic [7:0] d);
        @(negedge clk);
        ui_in  = {1'b0, 1'b1, rs, op};
        uio_in = d;
        @(negedge clk);
        ui_in[6] = 1'b0;
    endtask

    task automatic expect_out(input logic sel, input logic [7:0] e, input string nm);
        @(negedge clk);
        ui_in[7] = sel;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(negedge clk);
        chk_req = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        expect_out(1'b0, 8'h00, "reset_acc");
        expect_out(1'b1, 8'h01, "reset_status");

        @(negedge clk);
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL bidir_tie: got out=%h oe=%h expected 00/00", uio_out, uio_oe);
        end

        exec(4'h1, 2'd0, 8'h7F);                    // LD 7F
        exec(4'h2, 2'd0, 8'h01);                    // ADD 01
        expect_out(1'b0, 8'h80, "add_ovf_acc");
        expect_out(1'b1, 8'h2C, "add_ovf_status");

        exec(4'h1, 2'd0, 8'hFF);                    // LD FF
        exec(4'hE, 2'd0, 8'h00);                    // INC
        expect_out(1'b0, 8'h00, "inc_wrap_acc");
        expect_out(1'b1, 8'h43, "inc_wrap_status");
        exec(4'h3, 2'd0, 8'h01);                    // SUB 01
        expect_out(1'b0, 8'hFF, "sub_borrow_acc");
        expect_out(1'b1, 8'h56, "sub_borrow_status");

        exec(4'h1, 2'd0, 8'h5A);                    // LD 5A
        exec(4'hB, 2'd2, 8'h00);                    // ST R2
        exec(4'hF, 2'd0, 8'h00);                    // CLR
        expect_out(1'b0, 8'h00, "clr_acc");
        expect_out(1'b1, 8'h81, "clr_status");
        exec(4'hC, 2'd2, 8'h00);                    // MOV R2
        expect_out(1'b0, 8'h5A, "mov_acc");
        expect_out(1'b1, 8'h90, "mov_status");
        exec(4'hD, 2'd2, 8'h00);                    // ADR R2
        expect_out(1'b0, 8'hB4, "adr_acc");
        expect_out(1'b1, 8'hAC, "adr_status");

        // INC with strobe held high for 5 cycles executes once
        @(negedge clk);
        ui_in = {1'b0, 1'b1, 2'd0, 4'hE};
        repeat (5) @(negedge clk);
        ui_in[6] = 1'b0;
        expect_out(1'b0, 8'hB5, "hold_acc");
        expect_out(1'b1, 8'hB4, "hold_status");

        // Strobe while disabled: LD 00 must be ignored
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = {1'b0, 1'b1, 2'd0, 4'h1};
        uio_in = 8'h00;
        @(negedge clk);
        ui_in[6] = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        expect_out(1'b0, 8'hB5, "ena_off_acc");
        expect_out(1'b1, 8'hB4, "ena_off_status");

        exec(4'h6, 2'd0, 8'hFF);                    // XOR FF -> 4A
        expect_out(1'b1, 8'hC0, "xor_status");
        exec(4'h7, 2'd0, 8'h00);                    // SHL -> 94
        expect_out(1'b0, 8'h94, "shl_acc");
        exec(4'h7, 2'd0, 8'h00);                    // SHL -> 28, C=1
        expect_out(1'b1, 8'hE2, "shl_carry_status");
        exec(4'hA, 2'd0, 8'h00);                    // ROR -> 94, C=0
        expect_out(1'b0, 8'h94, "ror_acc");
        expect_out(1'b1, 8'hF4, "ror_status");
        exec(4'h9, 2'd0, 8'h00);                    // ROL -> 28, C=1, opcnt wraps
        expect_out(1'b0, 8'h28, "rol_acc");
        expect_out(1'b1, 8'h02, "rol_wrap_status");
        exec(4'h8, 2'd0, 8'h00);                    // SHR -> 14, C=0
        expect_out(1'b0, 8'h14, "shr_acc");
        exec(4'h4, 2'd0, 8'h0F);                    // AND 0F -> 04
        expect_out(1'b1, 8'h20, "and_status");
        exec(4'h5, 2'd0, 8'hF0);                    // OR F0 -> F4
        expect_out(1'b1, 8'h34, "or_status");
        exec(4'h2, 2'd0, 8'h80);                    // ADD 80 -> 74, C=1, V=1
        expect_out(1'b0, 8'h74, "add_cv_acc");
        expect_out(1'b1, 8'h4A, "add_cv_status");

        for (int i = 0; i < 16; i++) begin
            exec(4'h0, 2'd0, 8'h00);
        end
        expect_out(1'b0, 8'h74, "nop16_acc");
        expect_out(1'b1, 8'h4A, "nop16_status");

        // Strobe under reset must be discarded
        @(negedge clk);
        rst    = 1'b1;
        ui_in  = {1'b0, 1'b1, 2'd0, 4'h1};
        uio_in = 8'h55;
        repeat (2) @(negedge clk);
        ui_in[6] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expect_out(1'b0, 8'h00, "rst_strobe_acc");
        expect_out(1'b1, 8'h01, "rst_strobe_status");

        exec(4'h1, 2'd0, 8'h33);
        expect_out(1'b0, 8'h33, "post_rst_ld_acc");
        expect_out(1'b1, 8'h10, "post_rst_ld_status");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
